// File: rtl/ahb3_pkg.sv
// ahb3_pkg: shared AHB3-lite transfer, size and response codes.
package ahb3_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_e;
  typedef enum logic [2:0] {BYTE, HALF, WORD} hsize_e;
  typedef enum logic {OKAY, ERROR} hresp_e;
endpackage

// File: rtl/ahb3_dummy_slave.sv
// ahb3_dummy_slave: zero-wait AHB3-lite RAM slave; AHB3_DUMMY_WAIT_EN adds one wait state per data phase.
module ahb3_dummy_slave
  import ahb3_pkg::*;
#(
  parameter int ADDRSIZE = 8
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        HREADY_o,
  output logic        HRESP_o,
  output logic [31:0] HRDATA_o,
  input  logic [31:0] HADDR_i,
  input  logic        HWRITE_i,
  input  logic [2:0]  HSIZE_i,
  input  logic [2:0]  HBURST_i,
  input  logic [3:0]  HPROT_i,
  input  logic [1:0]  HTRANS_i,
  input  logic        HMASTLOCK_i,
  input  logic [31:0] HWDATA_i
);
  localparam int WORDS = 2 ** (ADDRSIZE - 2);
  logic                active, hwrite, hready;
  logic [31:0]         haddr;
  logic [2:0]          hsize;
  logic [3:0]          be;
  logic [ADDRSIZE-3:0] widx;
  logic [31:0]         mem [WORDS];
  logic                unused;
  assign unused = ^{HBURST_i, HPROT_i, HMASTLOCK_i, HTRANS_i[0], HADDR_i[31:ADDRSIZE], haddr[31:ADDRSIZE]};
  assign widx = haddr[ADDRSIZE-1:2];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active <= 1'b0;
      hwrite <= 1'b0;
      haddr  <= '0;
      hsize  <= '0;
    end else if (hready) begin
      active <= HTRANS_i[1];
      hwrite <= HTRANS_i[1] & HWRITE_i;
      if (HTRANS_i[1]) begin
        haddr <= {{(32-ADDRSIZE){1'b0}}, HADDR_i[ADDRSIZE-1:0]};
        hsize <= HSIZE_i;
      end
    end
  end
`ifdef AHB3_DUMMY_WAIT_EN
  logic wt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wt <= 1'b0;
    else wt <= active & !wt;
  end
  assign hready = !active | wt;
`else
  assign hready = 1'b1;
`endif
  // sizes above WORD fall through to a full-word enable
  assign be = hsize == BYTE ? 4'b0001 << haddr[1:0] :
              hsize == HALF ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk) begin
    if (active & hwrite & hready)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[widx][8*i +: 8] <= HWDATA_i[8*i +: 8];
  end
  assign HRDATA_o = (active & !hwrite) ? mem[widx] : '0;
  assign HREADY_o = hready;
  assign HRESP_o  = OKAY;
endmodule

// File: tb/tb_ahb3_dummy_slave.sv
// tb_ahb3_dummy_slave: randomized scoreboard bench against a byte-array memory model.
module tb_ahb3_dummy_slave;
  logic        clk = 1'b0, resetn;
  logic        HREADY_o, HRESP_o, HWRITE_i, HMASTLOCK_i;
  logic [31:0] HRDATA_o, HADDR_i, HWDATA_i;
  logic [2:0]  HSIZE_i, HBURST_i;
  logic [3:0]  HPROT_i;
  logic [1:0]  HTRANS_i;
  logic [7:0]  mem_m [256];
  logic [31:0] exp_q [$];
  logic [31:0] pend;
  logic        ph_rd, ph_wr, skip;
  int          n_chk = 0, n_fail = 0;

  ahb3_dummy_slave #(.ADDRSIZE(8)) dut (
    .clk(clk), .resetn(resetn), .HREADY_o(HREADY_o), .HRESP_o(HRESP_o), .HRDATA_o(HRDATA_o),
    .HADDR_i(HADDR_i), .HWRITE_i(HWRITE_i), .HSIZE_i(HSIZE_i), .HBURST_i(HBURST_i),
    .HPROT_i(HPROT_i), .HTRANS_i(HTRANS_i), .HMASTLOCK_i(HMASTLOCK_i), .HWDATA_i(HWDATA_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // which kind of data phase the bench itself expects this cycle
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ph_rd <= 1'b0;
      ph_wr <= 1'b0;
    end else begin
      ph_rd <= HTRANS_i[1] & !HWRITE_i;
      ph_wr <= HTRANS_i[1] & HWRITE_i;
    end
  end

  always @(negedge clk) begin
    chk("hready", {31'b0, HREADY_o}, 32'd1);
    chk("hresp", {31'b0, HRESP_o}, 32'd0);
    chk("hwrite", {31'b0, dut.hwrite}, {31'b0, ph_wr});
    if (ph_rd) begin
      if (exp_q.size() == 0) chk("rd_without_expect", HRDATA_o, 32'hxxxxxxxx);
      else chk("hrdata", HRDATA_o, exp_q.pop_front());
    end else chk("hrdata_idle", HRDATA_o, 32'd0);
  end

  task automatic xfer(input logic [1:0] t, input logic w, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] d);
    int b;
    bit sel;
    @(posedge clk);
    #1;
    HTRANS_i = t; HWRITE_i = w; HADDR_i = a; HSIZE_i = s;
    HWDATA_i = pend; pend = d;
    b = int'(a & 32'hFF);
    if (t[1] && !skip) begin
      if (w) begin
        for (int l = 0; l < 4; l++) begin
          sel = s == 0 ? (l == b % 4) : s == 1 ? (l / 2 == (b / 2) % 2) : 1'b1;
          if (sel) mem_m[(b & ~3) + l] = d[8*l +: 8];
        end
      end else begin
        b = b & ~3;
        exp_q.push_back({mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    resetn = 1'b0; skip = 1'b0; pend = '0;
    HTRANS_i = 2'd0; HWRITE_i = 1'b0; HADDR_i = '0; HSIZE_i = '0; HWDATA_i = '0;
    HBURST_i = '0; HPROT_i = '0; HMASTLOCK_i = 1'b0;
    @(posedge clk); #1;
    chk("rst_haddr", dut.haddr, 32'd0);
    chk("rst_active", {31'b0, dut.active}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    xfer(2'd2, 1'b1, 32'h04, 3'd2, 32'hDEADBEEF);
    xfer(2'd2, 1'b0, 32'h04, 3'd2, 32'h0);
    xfer(2'd2, 1'b1, 32'h05, 3'd0, 32'h0000AA00);
    xfer(2'd2, 1'b0, 32'h04, 3'd2, 32'h0);
    xfer(2'd2, 1'b1, 32'h06, 3'd1, 32'h12340000);
    xfer(2'd2, 1'b0, 32'h04, 3'd2, 32'h0);
    xfer(2'd2, 1'b1, 32'h08, 3'd2, 32'h11111111);
    xfer(2'd3, 1'b0, 32'h08, 3'd2, 32'h0);
    xfer(2'd0, 1'b1, 32'h0C, 3'd2, 32'h55555555);
    xfer(2'd1, 1'b1, 32'h0C, 3'd2, 32'h66666666);
    xfer(2'd2, 1'b0, 32'h0C, 3'd2, 32'h0);
    xfer(2'd2, 1'b1, 32'h104, 3'd2, 32'hCAFEF00D);
    xfer(2'd2, 1'b0, 32'h04, 3'd2, 32'h0);
    xfer(2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    skip = 1'b1;
    xfer(2'd2, 1'b1, 32'h20, 3'd2, 32'h12345678);
    skip = 1'b0;
    @(posedge clk); #1;
    HTRANS_i = 2'd0; HWRITE_i = 1'b0; HWDATA_i = pend; pend = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_hrdata", HRDATA_o, 32'd0);
    chk("rst_async_hready", {31'b0, HREADY_o}, 32'd1);
    chk("rst_async_hwrite", {31'b0, dut.hwrite}, 32'd0);
    chk("rst_async_haddr", dut.haddr, 32'd0);
    chk("rst_async_hsize", {29'b0, dut.hsize}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    resetn = 1'b1;
    xfer(2'd2, 1'b0, 32'h20, 3'd2, 32'h0);
    for (int k = 0; k < 300; k++)
      xfer(2'($urandom_range(3)), 1'($urandom_range(1)), $urandom(), 3'($urandom_range(7)), $urandom());
    for (int k = 0; k < 40; k++)
      xfer(2'd2, 1'b0, 32'($urandom_range(255)), 3'd2, 32'h0);
    xfer(2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    xfer(2'd0, 1'b0, 32'h0, 3'd0, 32'h0);
    @(posedge clk); #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
